// File: rtl/irq_ctrl_n_pkg.sv
// irq_pkg: shared FSM state type, id width and vector-address helper for irq_ctrl_n
package irq_pkg;
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
   localparam int N_DEF = 4;
   localparam int ID_W = $clog2(N_DEF);
   function automatic logic [15:0] vec_of(input logic [15:0] base, input logic [15:0] id);
      return base - (id << 1);
   endfunction
endpackage

// File: rtl/irq_ctrl_n_if.sv
// irq_ctrl_n_if: request/ack/done handshake and status bus between irq_ctrl_n and the control FSM
interface irq_ctrl_n_if #(parameter int N = 4) ();
   localparam int IW = $clog2(N);
   logic          ack;
   logic          done;
   logic          req_valid;
   logic [IW-1:0] req_id;
   logic [15:0]   vec_addr;
   logic [N-1:0]  pending;
   logic          in_service;
   modport master (output ack, done, input req_valid, req_id, vec_addr, pending, in_service);
   modport slave (input ack, done, output req_valid, req_id, vec_addr, pending, in_service);
endinterface

// File: rtl/irq_ctrl_n_sync_edge.sv
// irq_sync_edge: per-source synchroniser, falling-edge detector and sticky latch (or level pass-through)
module irq_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic EDGE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic int_l,
   input  logic clr,
   output logic raw
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [SYNC_STAGES:0]   shift;
   logic prev_q, prev_d, latch_q, latch_d, s;
   always_comb begin
      shift   = {sync_q, int_l};
      sync_d  = shift[SYNC_STAGES-1:0];
      s       = sync_q[SYNC_STAGES-1];
      prev_d  = s;
      // a new edge wins over a coincident clearing ack
      latch_d = EDGE & ((prev_q & ~s) | (latch_q & ~clr));
      raw     = EDGE ? latch_q : ~s;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '1;
         prev_q  <= 1'b1;
         latch_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         latch_q <= latch_d;
      end
   end
endmodule

// File: rtl/irq_ctrl_n.sv
// irq_ctrl_n: N-source fixed-priority interrupt controller with vector bus and request/ack/done handshake
module irq_ctrl_n
   import irq_pkg::*;
#(
   parameter int           N           = 4,
   parameter int           SYNC_STAGES = 2,
   parameter logic [N-1:0] EDGE_MASK   = N'(1),
   parameter logic [N-1:0] NMI_MASK    = N'(1),
   parameter logic [15:0]  VEC_BASE    = 16'hFFFE
) (
   input  logic         phi2,
   input  logic         RES,
   input  logic [N-1:0] INT_L,
   input  logic         I_flag,
   irq_ctrl_n_if.slave  bus
);
   localparam int IW = $clog2(N);
   logic [N-1:0]  raw, elig, clr, pending_q, pending_d;
   logic [IW-1:0] win, req_id_q, req_id_d;
   logic [15:0]   vec_q, vec_d;
   logic          req_valid_q, req_valid_d, in_service_q, in_service_d;
   state_t        state_q, state_d;
   for (genvar i = 0; i < N; i++) begin : g_src
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE(EDGE_MASK[i])) u_src (
         .clk(phi2), .rst(RES), .int_l(INT_L[i]), .clr(clr[i]), .raw(raw[i])
      );
   end
   always_comb begin
      elig = raw & (NMI_MASK | {N{~I_flag}});
      pending_d = elig;
      win = '0;
      for (int i = N - 1; i >= 0; i--) if (elig[i]) win = IW'(i);
   end
   always_comb begin
      state_d      = state_q;
      req_valid_d  = req_valid_q;
      req_id_d     = req_id_q;
      vec_d        = vec_q;
      in_service_d = in_service_q;
      clr          = '0;
      case (state_q)
         IDLE: if (|elig) begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_id_d    = win;
            vec_d       = vec_of(VEC_BASE, 16'(win));
         end
         REQ: if (bus.ack) begin
            state_d      = SERVICE;
            req_valid_d  = 1'b0;
            in_service_d = 1'b1;
            clr          = N'(1) << req_id_q;
         end else if (~|elig) begin
            state_d     = IDLE;
            req_valid_d = 1'b0;
         end else begin
            req_id_d = win;
            vec_d    = vec_of(VEC_BASE, 16'(win));
         end
         SERVICE: if (bus.done) begin
            state_d      = IDLE;
            in_service_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge phi2) begin
      if (RES) begin
         state_q      <= IDLE;
         req_valid_q  <= 1'b0;
         req_id_q     <= '0;
         vec_q        <= VEC_BASE;
         pending_q    <= '0;
         in_service_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_valid_q  <= req_valid_d;
         req_id_q     <= req_id_d;
         vec_q        <= vec_d;
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
      end
   end
   assign bus.req_valid  = req_valid_q;
   assign bus.req_id     = req_id_q;
   assign bus.vec_addr   = vec_q;
   assign bus.pending    = pending_q;
   assign bus.in_service = in_service_q;
endmodule

// File: tb/tb_irq_ctrl_n.sv
// tb_irq_ctrl_n: directed self-checking bench for irq_ctrl_n with default parameters
module tb_irq_ctrl_n;
   logic       phi2 = 1'b0;
   logic       RES = 1'b1;
   logic [3:0] INT_L = 4'hF;
   logic       I_flag = 1'b0;
   int checks = 0;
   int failures = 0;
   irq_ctrl_n_if #(.N(4)) bus ();
   irq_ctrl_n #(.N(4)) dut (.phi2(phi2), .RES(RES), .INT_L(INT_L), .I_flag(I_flag), .bus(bus));
   always #5 phi2 = ~phi2;
   task automatic step(input int n = 1);
      repeat (n) @(posedge phi2);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, 32'(bus.req_valid), 0);
      chk({tag, "_id"}, 32'(bus.req_id), 0);
      chk({tag, "_vec"}, 32'(bus.vec_addr), 32'hFFFE);
      chk({tag, "_pend"}, 32'(bus.pending), 0);
      chk({tag, "_insvc"}, 32'(bus.in_service), 0);
   endtask
   task automatic pulse0();
      INT_L = 4'hE;
      step();
      INT_L = 4'hF;
   endtask
   initial begin
      bus.ack = 1'b0;
      bus.done = 1'b0;
      step(2);
      RES = 1'b0;
      chk_reset("reset");
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_valid", 32'(bus.req_valid), 0);
         chk("idle_pend", 32'(bus.pending), 0);
         chk("idle_vec", 32'(bus.vec_addr), 32'hFFFE);
      end
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      chk("spurious_ack", 32'(bus.in_service), 0);
      // edge source 0: request appears 4 edges after the pin is sampled low
      pulse0();
      step(2);
      chk("edge0_early", 32'(bus.req_valid), 0);
      step();
      chk("edge0_valid", 32'(bus.req_valid), 1);
      chk("edge0_id", 32'(bus.req_id), 0);
      chk("edge0_vec", 32'(bus.vec_addr), 32'hFFFE);
      chk("edge0_pend", 32'(bus.pending), 4'b0001);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      chk("edge0_ack_valid", 32'(bus.req_valid), 0);
      chk("edge0_insvc", 32'(bus.in_service), 1);
      step();
      chk("edge0_cleared", 32'(bus.pending), 0);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      chk("edge0_done", 32'(bus.in_service), 0);
      step(3);
      chk("edge0_norepeat", 32'(bus.req_valid), 0);
      // masked level source 2
      I_flag = 1'b1;
      INT_L = 4'hB;
      step(5);
      chk("mask_valid", 32'(bus.req_valid), 0);
      chk("mask_pend", 32'(bus.pending), 0);
      I_flag = 1'b0;
      step(2);
      chk("lvl2_valid", 32'(bus.req_valid), 1);
      chk("lvl2_id", 32'(bus.req_id), 2);
      chk("lvl2_vec", 32'(bus.vec_addr), 32'hFFFA);
      chk("lvl2_pend", 32'(bus.pending), 4'b0100);
      INT_L = 4'hF;
      step(3);
      chk("lvl2_drop_valid", 32'(bus.req_valid), 0);
      chk("lvl2_drop_pend", 32'(bus.pending), 0);
      // pre-emption of level source 3 by edge source 0
      INT_L = 4'h7;
      step(3);
      chk("lvl3_valid", 32'(bus.req_valid), 1);
      chk("lvl3_id", 32'(bus.req_id), 3);
      chk("lvl3_vec", 32'(bus.vec_addr), 32'hFFF8);
      INT_L = 4'h6;
      step();
      INT_L = 4'h7;
      step(2);
      chk("pre_before", 32'(bus.req_id), 3);
      step();
      chk("pre_id", 32'(bus.req_id), 0);
      chk("pre_vec", 32'(bus.vec_addr), 32'hFFFE);
      chk("pre_valid", 32'(bus.req_valid), 1);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      chk("pre_insvc", 32'(bus.in_service), 1);
      step();
      chk("pre_svc_valid", 32'(bus.req_valid), 0);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      chk("pre_done_valid", 32'(bus.req_valid), 0);
      step();
      chk("b2b_valid", 32'(bus.req_valid), 1);
      chk("b2b_id", 32'(bus.req_id), 3);
      chk("b2b_vec", 32'(bus.vec_addr), 32'hFFF8);
      INT_L = 4'hF;
      step(3);
      chk("lvl3_drop", 32'(bus.req_valid), 0);
      // edge captured while in service
      pulse0();
      step(3);
      chk("svc0_valid", 32'(bus.req_valid), 1);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      pulse0();
      step(3);
      chk("svc_latch_pend", 32'(bus.pending), 4'b0001);
      chk("svc_latch_valid", 32'(bus.req_valid), 0);
      chk("svc_latch_insvc", 32'(bus.in_service), 1);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      step();
      chk("second0_valid", 32'(bus.req_valid), 1);
      chk("second0_id", 32'(bus.req_id), 0);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      step(2);
      chk("second0_clear", 32'(bus.req_valid), 0);
      // reset mid-REQ discards the latched edge
      pulse0();
      step(3);
      chk("res_pre_valid", 32'(bus.req_valid), 1);
      RES = 1'b1;
      step();
      RES = 1'b0;
      chk_reset("midres");
      step(5);
      chk("midres_lost_valid", 32'(bus.req_valid), 0);
      chk("midres_lost_pend", 32'(bus.pending), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/irq_ctrl_n.md
Name: irq_ctrl_n

Overview:
- Parametrised successor to the fixed three-line NMI/IRQ/RES pending logic.
- Accepts N active-low interrupt sources. Each source is configured as edge-latched (NMI-style) or level-sensitive (IRQ-style), and as maskable or non-maskable.
- Arbitrates sources by fixed priority, presents one request with its vector address to the control FSM, and runs a request/ack/done handshake.
- Sits between the external interrupt pins and the PLA FSM; replaces per-line pending wires with a vector bus.

Parameters:
- N, 4: number of interrupt sources (2..16); index 0 is highest priority.
- SYNC_STAGES, 2: input synchroniser depth (1..3).
- EDGE_MASK, 4'b0001: bit i=1 makes source i edge-latched (falling edge); 0 makes it level-sensitive.
- NMI_MASK, 4'b0001: bit i=1 makes source i ignore I_flag (non-maskable).
- VEC_BASE, 16'hFFFE: vector address of source 0; source i maps to VEC_BASE - 2*i.

Ports:
- phi2  in  1  system clock; all state updates on its rising edge.
- RES  in  1  synchronous, active-high reset.
- INT_L  in  N  active-low interrupt lines, asynchronous to phi2.
- I_flag  in  1  interrupt-disable bit from the status register; 1 masks maskable sources.
- ack  in  1  FSM accepts the presented request (single-cycle pulse).
- done  in  1  FSM finished the service sequence (single-cycle pulse).
- req_valid  out  1  a request is presented.
- req_id  out  $clog2(N)  index of the presented source.
- vec_addr  out  16  VEC_BASE - 2*req_id, registered.
- pending  out  N  per-source pending vector, after masking.
- in_service  out  1  high from ack until done.

Behaviour:
- Reset: all synchroniser flops = 1 (inactive), edge latches = 0, state = IDLE. req_valid=0, req_id=0, vec_addr=VEC_BASE, pending=0, in_service=0.
- Synchroniser: INT_L passes through SYNC_STAGES flops. A further history flop s_prev is used for edge detection.
- Edge source i: the latch sets when s_prev[i]=1 and s[i]=0, then holds until cleared. It clears only on an ack cycle with req_id==i. If a new falling edge coincides with that clearing ack, the latch stays set (the set wins).
- Level source i: raw_i = ~s[i]. No latch; ack has no effect; the source itself must deassert.
- Eligibility: elig[i] = raw_or_latch[i] & (NMI_MASK[i] | ~I_flag). pending = elig, registered.
- Arbiter: the lowest set index of elig wins (combinational priority encoder).
- States:
  - IDLE: if elig != 0, go to REQ next cycle. Load req_id with the winner and vec_addr with its address; set req_valid=1.
  - REQ: req_id and vec_addr are re-evaluated every cycle, so a higher-priority arrival pre-empts before ack.
    - If elig becomes 0 (a level source dropped, or I_flag rose), return to IDLE with req_valid=0.
    - On ack: go to SERVICE, set req_valid=0 and in_service=1, freeze req_id and vec_addr, and clear the edge latch of req_id.
  - SERVICE: no new request is presented; latches continue to capture edges. On done, set in_service=0 and go to IDLE; re-arbitration happens in the IDLE cycle, so a back-to-back request appears 2 cycles after done.
- Minimum latency, pin falling edge to req_valid: SYNC_STAGES + 2 phi2 cycles.
- Spurious handshakes: ack while not in REQ is ignored; done while not in SERVICE is ignored.
- RES mid-operation: all state returns to reset values on the next edge; latched edges are discarded.
- Simultaneous ack and higher-priority arrival: ack applies to the req_id shown that cycle.

Decomposition:
- Shared package irq_pkg:
  - state enum {IDLE, REQ, SERVICE}.
  - function vec_of(base, id).
  - localparam ID_W = $clog2(N).
- One natural sub-module: irq_sync_edge, holding the per-source synchroniser, edge detector and latch. Instantiate it N times; the top level holds the arbiter and FSM.

Test Plan:
- Reset, then idle: hold INT_L=4'hF for 10 cycles -> req_valid=0, pending=0, vec_addr=16'hFFFE throughout.
- Edge source 0, defaults: pulse INT_L[0] low for 1 cycle.
  - req_valid=1 and req_id=0 at cycle 4 after the edge; vec_addr=16'hFFFE.
  - ack clears the latch; in_service=1; done returns to IDLE; no repeat request.
- Level source 2 masked: I_flag=1 and INT_L[2] held low -> no request.
  - Drop I_flag to 0 -> req_id=2 and vec_addr=16'hFFFA after 2 cycles.
  - Release INT_L[2] before ack -> back to IDLE with req_valid=0.
- Pre-emption: level source 3 presented (vec 16'hFFF8); then pulse INT_L[0] before ack.
  - req_id switches to 0.
  - ack services 0; after done, source 3 is presented again (req_id=3) 2 cycles later.
- Edge during service: with source 0 in SERVICE, pulse INT_L[0] again -> latch set; after done, a second request for source 0 appears.
- Reset mid-REQ: assert RES for 1 cycle while req_valid=1 -> all outputs at reset values next cycle; the previously latched edge is lost.
